fft_stream_ctrl: RTL and testbench

FFT_STREAM_CTRL -- requirements
Module: fft_stream_ctrl

---
 rtl/fft_stream_ctrl_if.sv | 43 ++++
 rtl/fft_stream_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_fft_stream_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_stream_ctrl_if
// Brief    : Sample input, FFT sink and FFT source signals of fft_stream_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_stream_ctrl_if #(
    parameter int DATA_W = 14,
    parameter int PTS_W  = 11
);
    logic              in_valid;
    logic [DATA_W-1:0] in_sample;

    logic              sink_ready;
    logic              sink_valid;
    logic              sink_sop;
    logic              sink_eop;
    logic [DATA_W-1:0] sink_real;
    logic [DATA_W-1:0] sink_imag;
    logic [PTS_W-1:0]  fft_pts;

    logic              source_valid;
    logic              source_sop;
    logic              source_eop;
    logic [PTS_W-1:0]  bin_idx;

    // Controller side
    modport master (
        input  in_valid, in_sample, sink_ready,
        input  source_valid, source_sop, source_eop,
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fft_pts,
        output bin_idx
    );

    // ADC / FFT core side
    modport slave (
        output in_valid, in_sample, sink_ready,
        output source_valid, source_sop, source_eop,
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fft_pts,
        input  bin_idx
    );
endinterface
`default_nettype wire

// File: rtl/fft_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_stream_ctrl
// Brief    : Buffers ADC samples in a FWFT FIFO, frames them into FFT-length
//            sink packets, and checks framing of the FFT source stream.
// Revision : 1.0 - initial release
// ============================================================================
module fft_stream_ctrl #(
    parameter int DATA_W     = 14,
    parameter int PTS_W      = 11,
    parameter int FFT_LEN    = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  wire            clk,
    input  wire            reset,
    input  wire            enable,
    input  wire            clr_err,
    fft_stream_ctrl_if.master bus,
    output logic           frame_done,
    output logic           busy,
    output logic           ovf_err,
    output logic           frm_err
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_IW = $clog2(FFT_LEN);
    localparam logic [c_AW:0]      c_DEPTH    = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_IW-1:0]    c_LAST_IDX = c_IW'(FFT_LEN - 1);
    localparam logic [PTS_W-1:0]   c_LAST_BIN = PTS_W'(FFT_LEN - 1);
    localparam logic [PTS_W-1:0]   c_FFT_PTS  = PTS_W'(FFT_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_AW:0]     wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]     rd_ptr_q, rd_ptr_d;
    logic [c_IW-1:0]   idx_q, idx_d;
    logic [PTS_W-1:0]  bin_q, bin_d;
    logic              open_q, open_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              frm_q, frm_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic              w_active;
    logic [c_AW:0]     w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_last;
    logic              w_sink_valid;
    logic              w_beat;
    logic              w_push;
    logic              w_drop;
    logic              w_flush;
    logic              w_frm_evt;

    // ------------------------------------------------------------------
    // Input FIFO status
    // ------------------------------------------------------------------
    assign w_active     = (state_q != ST_IDLE);
    assign w_count      = wr_ptr_q - rd_ptr_q;
    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == c_DEPTH);
    assign w_last       = (idx_q == c_LAST_IDX);
    assign w_sink_valid = w_active && !w_empty;
    assign w_beat       = w_sink_valid && bus.sink_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push       = w_active && bus.in_valid && (!w_full || w_beat);
    assign w_drop       = w_active && bus.in_valid && w_full && !w_beat;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        w_flush = 1'b0;
        idx_d   = idx_q;
        if (w_beat) begin
            idx_d = w_last ? '0 : idx_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_STREAM;
                    w_flush = 1'b1;
                    idx_d   = '0;
                end
            end
            ST_STREAM: begin
                // Judge the boundary after this cycle's beat so a sop beat
                // accepted now is never left as an orphan frame.
                if (!enable) begin
                    state_d = (idx_d == '0) ? ST_IDLE : ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (w_beat && w_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{c_AW{1'b0}}, w_push};
        rd_ptr_d = rd_ptr_q + {{c_AW{1'b0}}, w_beat};
        if (w_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= bus.in_sample;
        end
    end

    // ------------------------------------------------------------------
    // FFT source framing monitor
    // ------------------------------------------------------------------
    always_comb begin
        bin_d     = bin_q;
        open_d    = open_q;
        done_d    = 1'b0;
        w_frm_evt = 1'b0;
        if (bus.source_valid) begin
            if (bus.source_sop) begin
                bin_d  = '0;
                open_d = 1'b1;
                if (open_q) begin
                    w_frm_evt = 1'b1;
                end
            end else begin
                if (!open_q) begin
                    w_frm_evt = 1'b1;
                end
                if (bin_q != c_LAST_BIN) begin
                    bin_d = bin_q + 1'b1;
                end
            end
            if (bus.source_eop) begin
                open_d = 1'b0;
                if (bin_d != c_LAST_BIN) begin
                    w_frm_evt = 1'b1;
                end
            end
            done_d = bus.source_eop && !w_frm_evt;
        end
    end

    // A fresh error outranks a simultaneous clear.
    always_comb begin
        ovf_d = w_drop    || (ovf_q && !clr_err);
        frm_d = w_frm_evt || (frm_q && !clr_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idx_q    <= '0;
            bin_q    <= '0;
            open_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            frm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            bin_q    <= bin_d;
            open_q   <= open_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            frm_q    <= frm_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.sink_valid = w_sink_valid;
    assign bus.sink_real  = w_sink_valid ? mem_q[rd_ptr_q[c_AW-1:0]] : '0;
    assign bus.sink_sop   = w_sink_valid && (idx_q == '0);
    assign bus.sink_eop   = w_sink_valid && w_last;
    assign bus.sink_imag  = '0;
    assign bus.fft_pts    = c_FFT_PTS;
    assign bus.bin_idx    = bin_q;

    assign frame_done = done_q;
    assign busy       = w_active;
    assign ovf_err    = ovf_q;
    assign frm_err    = frm_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_stream_ctrl
// Brief    : Scoreboard bench for fft_stream_ctrl with an 8-point frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_stream_ctrl;

    localparam int DW    = 14;
    localparam int PW    = 11;
    localparam int LEN   = 8;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic clr_err;
    logic frame_done, busy, ovf_err, frm_err;

    fft_stream_ctrl_if #(.DATA_W(DW), .PTS_W(PW)) bus ();

    fft_stream_ctrl #(
        .DATA_W    (DW),
        .PTS_W     (PW),
        .FFT_LEN   (LEN),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clr_err   (clr_err),
        .bus       (bus.master),
        .frame_done(frame_done),
        .busy      (busy),
        .ovf_err   (ovf_err),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    int    n_cmp    = 0;
    int    n_bad    = 0;
    int    n_in     = 0;
    int    n_done   = 0;
    int    exp_done = 0;
    bit    hold_chk = 1'b1;
    bit    stall_prev = 1'b0;
    beat_t prev_beat;
    beat_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sink monitor: pops the scoreboard on each accepted beat and checks
    // that a stalled beat is held unchanged.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = '{d: bus.sink_real, sop: bus.sink_sop, eop: bus.sink_eop};
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && hold_chk) begin
                check("sink_hold", {15'd0, bus.sink_valid, cur}, {15'd0, 1'b1, prev_beat});
            end
            if (bus.sink_valid && bus.sink_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sink_extra: got beat %0h, expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("sink_beat", {16'd0, cur}, {16'd0, e});
                end
            end
            stall_prev = bus.sink_valid && !bus.sink_ready;
            prev_beat  = cur;
        end
    end

    always @(negedge clk) begin
        if (frame_done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input bit store);
        bus.in_valid  = 1'b1;
        bus.in_sample = DW'(v);
        if (store) begin
            exp_q.push_back('{d: DW'(v), sop: (n_in == 0), eop: (n_in == LEN - 1)});
            n_in = (n_in + 1) % LEN;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input bit toggle);
        int i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            if (toggle) bus.sink_ready = ~bus.sink_ready;
            tick();
            i++;
        end
        bus.sink_ready = 1'b1;
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic src_beat(input bit sop, input bit eop);
        bus.source_valid = 1'b1;
        bus.source_sop   = sop;
        bus.source_eop   = eop;
        @(posedge clk);
        #1;
        bus.source_valid = 1'b0;
        bus.source_sop   = 1'b0;
        bus.source_eop   = 1'b0;
        @(negedge clk);
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; clr_err = 1'b0;
        bus.in_valid = 1'b0; bus.in_sample = '0; bus.sink_ready = 1'b1;
        bus.source_valid = 1'b0; bus.source_sop = 1'b0; bus.source_eop = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {25'd0, bus.sink_valid, bus.sink_sop, bus.sink_eop,
                            frame_done, busy, ovf_err, frm_err}, 0);
        check("rst_sink_real", {18'd0, bus.sink_real}, 0);
        check("rst_bin_idx", {21'd0, bus.bin_idx}, 0);
        check("fft_pts", {21'd0, bus.fft_pts}, LEN);
        check("sink_imag", {18'd0, bus.sink_imag}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Continuous stream: three back-to-back frames
        enable = 1'b1;
        tick();
        n_in = 0;
        for (int n = 0; n < 24; n++) drive(n * 97 - 1100, 1'b1);
        drain("basic", 1'b0);
        @(negedge clk);
        check("basic_busy", {31'd0, busy}, 1);
        @(posedge clk); #1;

        // Input gaps mid-frame
        for (int k = 0; k < 8; k++) begin
            drive(3000 - k * 211, 1'b1);
            if (k % 3 == 1) begin
                tick();
                @(negedge clk);
                check("gap_valid_low", {31'd0, bus.sink_valid}, 0);
                @(posedge clk); #1;
            end
        end
        drain("gaps", 1'b0);

        // Overflow with sink stalled, then write-while-full with a pop
        bus.sink_ready = 1'b0;
        for (int n = 0; n < 16; n++) drive(-4000 + n * 300, 1'b1);
        @(negedge clk);
        check("ovf_before_full", {31'd0, ovf_err}, 0);
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) drive(777 + n, 1'b0);
        @(negedge clk);
        check("ovf_set", {31'd0, ovf_err}, 1);
        @(posedge clk); #1;
        clr_pulse();
        check("ovf_cleared", {31'd0, ovf_err}, 0);
        @(posedge clk); #1;
        bus.sink_ready = 1'b1;
        for (int n = 0; n < 8; n++) drive(5000 + n * 13, 1'b1);
        @(negedge clk);
        check("ovf_full_rw", {31'd0, ovf_err}, 0);
        @(posedge clk); #1;
        bus.sink_ready = 1'b0;
        drain("ovf", 1'b1);

        // Leftover data at a frame boundary is flushed on re-entry
        hold_chk = 1'b0;
        bus.sink_ready = 1'b0;
        for (int n = 0; n < 3; n++) drive(1234 + n, 1'b0);
        enable = 1'b0;
        tick();
        @(negedge clk);
        check("boundary_idle", {30'd0, busy, bus.sink_valid}, 0);
        @(posedge clk); #1;
        enable = 1'b1;
        bus.sink_ready = 1'b1;
        tick();
        @(negedge clk);
        check("flush_empty", {30'd0, busy, bus.sink_valid}, 2);
        @(posedge clk); #1;
        hold_chk = 1'b1;
        n_in = 0;
        for (int n = 0; n < 8; n++) drive(-n * 555, 1'b1);
        drain("flush", 1'b0);

        // Enable dropped mid-frame at index 3
        for (int n = 0; n < 3; n++) drive(100 + n, 1'b1);
        tick();
        tick();
        enable = 1'b0;
        tick();
        @(negedge clk);
        check("finish_busy", {31'd0, busy}, 1);
        @(posedge clk); #1;
        for (int n = 3; n < 8; n++) drive(100 + n, 1'b1);
        for (int i = 0; i < 20 && busy; i++) tick();
        @(negedge clk);
        check("finish_idle", {31'd0, busy}, 0);
        @(posedge clk); #1;
        drain("finish", 1'b0);

        // Samples in IDLE are discarded silently
        bus.sink_ready = 1'b0;
        for (int n = 0; n < 20; n++) drive(2000 + n, 1'b0);
        @(negedge clk);
        check("idle_discard", {29'd0, ovf_err, bus.sink_valid, busy}, 0);
        @(posedge clk); #1;
        bus.sink_ready = 1'b1;

        // Reset in the middle of a frame
        enable = 1'b1;
        tick();
        n_in = 0;
        for (int n = 0; n < 5; n++) drive(-2000 + n, 1'b1);
        drain("pre_reset", 1'b0);
        bus.sink_ready = 1'b0;
        for (int n = 0; n < 2; n++) drive(4444, 1'b0);
        reset = 1'b1;
        #1;
        check("reset_async_flags", {25'd0, bus.sink_valid, bus.sink_sop, bus.sink_eop,
                                    frame_done, busy, ovf_err, frm_err}, 0);
        check("reset_async_real", {18'd0, bus.sink_real}, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.sink_ready = 1'b1;
        n_in = 0;
        tick();
        for (int n = 0; n < 8; n++) drive(333 * n - 1000, 1'b1);
        drain("after_reset", 1'b0);
        enable = 1'b0;
        tick();
        @(negedge clk);

        // Source framing monitor
        for (int k = 0; k < 8; k++) begin
            src_beat(k == 0, k == 7);
            check("bin_idx_seq", {21'd0, bus.bin_idx}, k);
        end
        exp_done++;
        check("done_pulse", {30'd0, frame_done, frm_err}, 2);
        @(negedge clk);
        check("done_one_cycle", {31'd0, frame_done}, 0);

        for (int k = 0; k < 6; k++) src_beat(k == 0, k == 5);
        check("short_eop", {30'd0, frame_done, frm_err}, 1);
        clr_pulse();
        check("frm_cleared", {31'd0, frm_err}, 0);

        src_beat(1'b1, 1'b0);
        src_beat(1'b0, 1'b0);
        check("bin_after_two", {21'd0, bus.bin_idx}, 1);
        check("no_err_in_frame", {31'd0, frm_err}, 0);
        src_beat(1'b1, 1'b0);
        check("sop_while_open", {30'd0, frm_err, bus.bin_idx == 0}, 3);
        clr_pulse();
        for (int k = 1; k < 10; k++) src_beat(1'b0, 1'b0);
        check("bin_saturate", {21'd0, bus.bin_idx}, LEN - 1);
        clr_err = 1'b1;
        src_beat(1'b0, 1'b1);
        clr_err = 1'b0;
        exp_done++;
        check("saturated_eop_done", {30'd0, frame_done, frm_err}, 2);

        src_beat(1'b0, 1'b0);
        check("orphan_beat", {31'd0, frm_err}, 1);
        clr_err = 1'b1;
        src_beat(1'b0, 1'b0);
        clr_err = 1'b0;
        check("err_beats_clear", {31'd0, frm_err}, 1);
        clr_pulse();
        check("frm_final_clear", {31'd0, frm_err}, 0);

        repeat (2) @(negedge clk);
        check("frame_done_count", n_done, exp_done);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
